// File: rtl/network_rx_steer.sv
// network_rx_steer: steers the NIC receive data (rxd) and status (rxs)
// AXI-Stream flows to exactly one of the trusted (T) or untrusted (U)
// consumers. The owner is locked when a frame starts. If ownership changes
// mid-frame, the remainder of that frame is discarded and counted.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   trusted_sel          desired owner (1 = T, 0 = U)
//   cnt_clr              single-cycle pulse clearing both drop counters
//   O_rx{d,s}_*          NIC-side streams (slave side of this block)
//   T_rx{d,s}_*          trusted consumer streams
//   U_rx{d,s}_*          untrusted consumer streams
//   rx{d,s}_drop_cnt     saturating count of truncated frames per stream
module network_rx_steer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  trusted_sel,
    input  logic                  cnt_clr,

    input  logic [DATA_W-1:0]     O_rxd_tdata,
    input  logic [DATA_W/8-1:0]   O_rxd_tkeep,
    input  logic                  O_rxd_tlast,
    input  logic                  O_rxd_tvalid,
    output logic                  O_rxd_tready,
    output logic [DATA_W-1:0]     T_rxd_tdata,
    output logic [DATA_W/8-1:0]   T_rxd_tkeep,
    output logic                  T_rxd_tlast,
    output logic                  T_rxd_tvalid,
    input  logic                  T_rxd_tready,
    output logic [DATA_W-1:0]     U_rxd_tdata,
    output logic [DATA_W/8-1:0]   U_rxd_tkeep,
    output logic                  U_rxd_tlast,
    output logic                  U_rxd_tvalid,
    input  logic                  U_rxd_tready,

    input  logic [DATA_W-1:0]     O_rxs_tdata,
    input  logic [DATA_W/8-1:0]   O_rxs_tkeep,
    input  logic                  O_rxs_tlast,
    input  logic                  O_rxs_tvalid,
    output logic                  O_rxs_tready,
    output logic [DATA_W-1:0]     T_rxs_tdata,
    output logic [DATA_W/8-1:0]   T_rxs_tkeep,
    output logic                  T_rxs_tlast,
    output logic                  T_rxs_tvalid,
    input  logic                  T_rxs_tready,
    output logic [DATA_W-1:0]     U_rxs_tdata,
    output logic [DATA_W/8-1:0]   U_rxs_tkeep,
    output logic                  U_rxs_tlast,
    output logic                  U_rxs_tvalid,
    input  logic                  U_rxs_tready,

    output logic [CNT_W-1:0]      rxd_drop_cnt,
    output logic [CNT_W-1:0]      rxs_drop_cnt
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned N_LANE = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD_T = 2'd1,
        FWD_U = 2'd2,
        DROP  = 2'd3
    } state_e;

    // Lane 0 carries rxd, lane 1 carries rxs; the two FSMs are independent.
    for (genvar g = 0; g < N_LANE; g++) begin : gen_lane
        logic [DATA_W-1:0] o_tdata;
        logic [KEEP_W-1:0] o_tkeep;
        logic              o_tlast;
        logic              o_tvalid;
        logic              o_tready;
        logic              t_tready;
        logic              u_tready;
        logic [DATA_W-1:0] t_tdata;
        logic [KEEP_W-1:0] t_tkeep;
        logic              t_tlast;
        logic              t_tvalid;
        logic [DATA_W-1:0] u_tdata;
        logic [KEEP_W-1:0] u_tkeep;
        logic              u_tlast;
        logic              u_tvalid;

        state_e            state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              route_t, route_u, sink, drop_inc, accept;

        assign o_tdata  = (g == 0) ? O_rxd_tdata  : O_rxs_tdata;
        assign o_tkeep  = (g == 0) ? O_rxd_tkeep  : O_rxs_tkeep;
        assign o_tlast  = (g == 0) ? O_rxd_tlast  : O_rxs_tlast;
        assign o_tvalid = (g == 0) ? O_rxd_tvalid : O_rxs_tvalid;
        assign t_tready = (g == 0) ? T_rxd_tready : T_rxs_tready;
        assign u_tready = (g == 0) ? U_rxd_tready : U_rxs_tready;

        // State and drop counter registers.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Routing, outputs, next state and counter update.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            route_t  = 1'b0;
            route_u  = 1'b0;
            sink     = 1'b0;
            drop_inc = 1'b0;

            // Ownership loss is evaluated every cycle, independent of tvalid.
            unique case (state_q)
                IDLE: begin
                    route_t = trusted_sel;
                    route_u = !trusted_sel;
                end
                FWD_T: begin
                    route_t  = trusted_sel;
                    sink     = !trusted_sel;
                    drop_inc = !trusted_sel;
                end
                FWD_U: begin
                    route_u  = !trusted_sel;
                    sink     = trusted_sel;
                    drop_inc = trusted_sel;
                end
                DROP: begin
                    sink = 1'b1;
                end
            endcase

            // Non-owner lanes are forced to zero so nothing leaks across.
            t_tvalid = route_t & o_tvalid;
            t_tdata  = route_t ? o_tdata : '0;
            t_tkeep  = route_t ? o_tkeep : '0;
            t_tlast  = route_t & o_tlast;
            u_tvalid = route_u & o_tvalid;
            u_tdata  = route_u ? o_tdata : '0;
            u_tkeep  = route_u ? o_tkeep : '0;
            u_tlast  = route_u & o_tlast;
            o_tready = sink | (route_t & t_tready) | (route_u & u_tready);
            accept   = o_tvalid & o_tready;

            unique case (state_q)
                IDLE: begin
                    if (accept && !o_tlast) begin
                        state_d = trusted_sel ? FWD_T : FWD_U;
                    end
                end
                FWD_T, FWD_U: begin
                    if (sink) begin
                        state_d = (accept && o_tlast) ? IDLE : DROP;
                    end else if (accept && o_tlast) begin
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (accept && o_tlast) begin
                        state_d = IDLE;
                    end
                end
            endcase

            // Clear has priority over a same-cycle increment; saturate at max.
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (drop_inc && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign O_rxd_tready = gen_lane[0].o_tready;
    assign T_rxd_tdata  = gen_lane[0].t_tdata;
    assign T_rxd_tkeep  = gen_lane[0].t_tkeep;
    assign T_rxd_tlast  = gen_lane[0].t_tlast;
    assign T_rxd_tvalid = gen_lane[0].t_tvalid;
    assign U_rxd_tdata  = gen_lane[0].u_tdata;
    assign U_rxd_tkeep  = gen_lane[0].u_tkeep;
    assign U_rxd_tlast  = gen_lane[0].u_tlast;
    assign U_rxd_tvalid = gen_lane[0].u_tvalid;
    assign rxd_drop_cnt = gen_lane[0].cnt_q;

    assign O_rxs_tready = gen_lane[1].o_tready;
    assign T_rxs_tdata  = gen_lane[1].t_tdata;
    assign T_rxs_tkeep  = gen_lane[1].t_tkeep;
    assign T_rxs_tlast  = gen_lane[1].t_tlast;
    assign T_rxs_tvalid = gen_lane[1].t_tvalid;
    assign U_rxs_tdata  = gen_lane[1].u_tdata;
    assign U_rxs_tkeep  = gen_lane[1].u_tkeep;
    assign U_rxs_tlast  = gen_lane[1].u_tlast;
    assign U_rxs_tvalid = gen_lane[1].u_tvalid;
    assign rxs_drop_cnt = gen_lane[1].cnt_q;

endmodule

// File: tb/tb_network_rx_steer.sv
// Bench for network_rx_steer: beats are queued per destination lane when
// driven and compared when the DUT hands them to T or U.
module tb_network_rx_steer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;
    localparam int D_T    = 0;
    localparam int D_U    = 1;
    localparam int D_DROP = 2;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
    } beat_t;

    logic clk = 1'b0;
    logic resetn, trusted_sel, cnt_clr;
    logic [DATA_W-1:0] O_rxd_tdata, T_rxd_tdata, U_rxd_tdata;
    logic [KEEP_W-1:0] O_rxd_tkeep, T_rxd_tkeep, U_rxd_tkeep;
    logic O_rxd_tlast, O_rxd_tvalid, O_rxd_tready;
    logic T_rxd_tlast, T_rxd_tvalid, T_rxd_tready;
    logic U_rxd_tlast, U_rxd_tvalid, U_rxd_tready;
    logic [DATA_W-1:0] O_rxs_tdata, T_rxs_tdata, U_rxs_tdata;
    logic [KEEP_W-1:0] O_rxs_tkeep, T_rxs_tkeep, U_rxs_tkeep;
    logic O_rxs_tlast, O_rxs_tvalid, O_rxs_tready;
    logic T_rxs_tlast, T_rxs_tvalid, T_rxs_tready;
    logic U_rxs_tlast, U_rxs_tvalid, U_rxs_tready;
    logic [CNT_W-1:0] rxd_drop_cnt, rxs_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    // Index: 0 = T rxd, 1 = U rxd, 2 = T rxs, 3 = U rxs
    beat_t exp_q [4][$];

    always #5 clk = ~clk;

    network_rx_steer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .trusted_sel(trusted_sel), .cnt_clr(cnt_clr),
        .O_rxd_tdata(O_rxd_tdata), .O_rxd_tkeep(O_rxd_tkeep), .O_rxd_tlast(O_rxd_tlast),
        .O_rxd_tvalid(O_rxd_tvalid), .O_rxd_tready(O_rxd_tready),
        .T_rxd_tdata(T_rxd_tdata), .T_rxd_tkeep(T_rxd_tkeep), .T_rxd_tlast(T_rxd_tlast),
        .T_rxd_tvalid(T_rxd_tvalid), .T_rxd_tready(T_rxd_tready),
        .U_rxd_tdata(U_rxd_tdata), .U_rxd_tkeep(U_rxd_tkeep), .U_rxd_tlast(U_rxd_tlast),
        .U_rxd_tvalid(U_rxd_tvalid), .U_rxd_tready(U_rxd_tready),
        .O_rxs_tdata(O_rxs_tdata), .O_rxs_tkeep(O_rxs_tkeep), .O_rxs_tlast(O_rxs_tlast),
        .O_rxs_tvalid(O_rxs_tvalid), .O_rxs_tready(O_rxs_tready),
        .T_rxs_tdata(T_rxs_tdata), .T_rxs_tkeep(T_rxs_tkeep), .T_rxs_tlast(T_rxs_tlast),
        .T_rxs_tvalid(T_rxs_tvalid), .T_rxs_tready(T_rxs_tready),
        .U_rxs_tdata(U_rxs_tdata), .U_rxs_tkeep(U_rxs_tkeep), .U_rxs_tlast(U_rxs_tlast),
        .U_rxs_tvalid(U_rxs_tvalid), .U_rxs_tready(U_rxs_tready),
        .rxd_drop_cnt(rxd_drop_cnt), .rxs_drop_cnt(rxs_drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one beat on lane 0 (rxd) or 1 (rxs) and wait until it is accepted.
    task automatic send(input int lane, input logic [DATA_W-1:0] d, input logic last, input int dest);
        beat_t b;
        logic  acc;
        b.d = d;
        b.k = d[KEEP_W-1:0] ^ 4'h5;
        b.l = last;
        if (dest != D_DROP) exp_q[lane*2 + dest].push_back(b);
        if (lane == 0) begin
            O_rxd_tdata = b.d; O_rxd_tkeep = b.k; O_rxd_tlast = b.l; O_rxd_tvalid = 1'b1;
        end else begin
            O_rxs_tdata = b.d; O_rxs_tkeep = b.k; O_rxs_tlast = b.l; O_rxs_tvalid = 1'b1;
        end
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = (lane == 0) ? O_rxd_tready : O_rxs_tready;
            if (dest == D_DROP && i == 0) check("drop_ready", 64'(acc), 64'd1);
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        if (lane == 0) begin
            O_rxd_tdata = '0; O_rxd_tkeep = '0; O_rxd_tlast = 1'b0; O_rxd_tvalid = 1'b0;
        end else begin
            O_rxs_tdata = '0; O_rxs_tkeep = '0; O_rxs_tlast = 1'b0; O_rxs_tvalid = 1'b0;
        end
    endtask

    // Output monitor: idle lanes must be all-zero; handshakes pop the scoreboard.
    always @(negedge clk) begin
        logic  v [4];
        logic  r [4];
        beat_t bt [4];
        beat_t e;
        if (mon_en) begin
            v[0] = T_rxd_tvalid; r[0] = T_rxd_tready; bt[0] = {T_rxd_tdata, T_rxd_tkeep, T_rxd_tlast};
            v[1] = U_rxd_tvalid; r[1] = U_rxd_tready; bt[1] = {U_rxd_tdata, U_rxd_tkeep, U_rxd_tlast};
            v[2] = T_rxs_tvalid; r[2] = T_rxs_tready; bt[2] = {T_rxs_tdata, T_rxs_tkeep, T_rxs_tlast};
            v[3] = U_rxs_tvalid; r[3] = U_rxs_tready; bt[3] = {U_rxs_tdata, U_rxs_tkeep, U_rxs_tlast};
            for (int i = 0; i < 4; i++) begin
                if (!v[i]) begin
                    check("idle_lane_zero", 64'(bt[i]), 64'd0);
                end else if (exp_q[i].size() == 0) begin
                    check("unexpected_valid", 64'(i), 64'hFF);
                end else if (r[i]) begin
                    e = exp_q[i].pop_front();
                    check("beat", 64'(bt[i]), 64'(e));
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; trusted_sel = 1'b1; cnt_clr = 1'b0;
        O_rxd_tdata = '0; O_rxd_tkeep = '0; O_rxd_tlast = 1'b0; O_rxd_tvalid = 1'b0;
        O_rxs_tdata = '0; O_rxs_tkeep = '0; O_rxs_tlast = 1'b0; O_rxs_tvalid = 1'b0;
        T_rxd_tready = 1'b1; U_rxd_tready = 1'b1; T_rxs_tready = 1'b1; U_rxs_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Reset state
        check("rst_rxd_cnt", 64'(rxd_drop_cnt), 64'd0);
        check("rst_rxs_cnt", 64'(rxs_drop_cnt), 64'd0);
        check("rst_t_valid", 64'(T_rxd_tvalid), 64'd0);
        check("rst_idle_ready_t", 64'(O_rxd_tready), 64'd1);
        trusted_sel = 1'b0; U_rxd_tready = 1'b0;
        #1;
        check("rst_idle_ready_u", 64'(O_rxd_tready), 64'd0);
        U_rxd_tready = 1'b1; trusted_sel = 1'b1;
        #1;

        // 4-beat frame to T
        for (int i = 1; i <= 4; i++) send(0, DATA_W'(i * 'h11), (i == 4), D_T);
        check("t1_cnt", 64'(rxd_drop_cnt), 64'd0);

        // 3-beat frame to U with 2-cycle stall on beat 2
        trusted_sel = 1'b0;
        send(0, 32'hA1, 1'b0, D_U);
        U_rxd_tready = 1'b0;
        fork
            send(0, 32'hA2, 1'b0, D_U);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("stall_ready", 64'(O_rxd_tready), 64'd0);
                    check("stall_hold", 64'(U_rxd_tdata), 64'hA2);
                end
                @(posedge clk);
                #1;
                U_rxd_tready = 1'b1;
            end
        join
        send(0, 32'hA3, 1'b1, D_U);
        check("t2_cnt", 64'(rxd_drop_cnt), 64'd0);

        // 6-beat frame truncated after beat 2
        trusted_sel = 1'b1;
        send(0, 32'hB1, 1'b0, D_T);
        send(0, 32'hB2, 1'b0, D_T);
        trusted_sel = 1'b0;
        for (int i = 3; i <= 6; i++) send(0, DATA_W'('hB0 + i), (i == 6), D_DROP);
        check("t3_cnt", 64'(rxd_drop_cnt), 64'd1);
        send(0, 32'hC1, 1'b1, D_U);

        // sel toggling while in DROP has no effect
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_cnt", 64'(rxd_drop_cnt), 64'd0);
        trusted_sel = 1'b1;
        send(0, 32'hD1, 1'b0, D_T);
        trusted_sel = 1'b0;
        send(0, 32'hD2, 1'b0, D_DROP);
        trusted_sel = 1'b1;
        send(0, 32'hD3, 1'b0, D_DROP);
        trusted_sel = 1'b0;
        send(0, 32'hD4, 1'b0, D_DROP);
        trusted_sel = 1'b1;
        send(0, 32'hD5, 1'b1, D_DROP);
        check("t4_cnt", 64'(rxd_drop_cnt), 64'd1);
        send(0, 32'hD6, 1'b1, D_T);

        // rxs counter saturation, then clear winning over increment
        for (int i = 0; i < 16; i++) begin
            trusted_sel = 1'b1;
            send(1, DATA_W'('h100 + i), 1'b0, D_T);
            trusted_sel = 1'b0;
            send(1, DATA_W'('h200 + i), 1'b1, D_DROP);
            if (i == 14) check("sat_reach", 64'(rxs_drop_cnt), 64'd15);
        end
        check("sat_hold", 64'(rxs_drop_cnt), 64'd15);
        check("rxd_indep", 64'(rxd_drop_cnt), 64'd1);
        trusted_sel = 1'b1;
        send(1, 32'h301, 1'b0, D_T);
        trusted_sel = 1'b0;
        cnt_clr = 1'b1;
        send(1, 32'h302, 1'b1, D_DROP);
        cnt_clr = 1'b0;
        check("clr_wins_rxs", 64'(rxs_drop_cnt), 64'd0);
        check("clr_wins_rxd", 64'(rxd_drop_cnt), 64'd0);

        // Reset in FWD_T mid-frame
        trusted_sel = 1'b1;
        send(0, 32'hE1, 1'b0, D_T);
        trusted_sel = 1'b0;
        send(0, 32'hE2, 1'b1, D_DROP);
        check("pre_rst_cnt", 64'(rxd_drop_cnt), 64'd1);
        trusted_sel = 1'b1;
        send(0, 32'hE3, 1'b0, D_T);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("mid_rst_cnt", 64'(rxd_drop_cnt), 64'd0);
        trusted_sel = 1'b0;
        send(0, 32'hE4, 1'b1, D_U);
        check("post_rst_cnt", 64'(rxd_drop_cnt), 64'd0);
        trusted_sel = 1'b1;
        send(0, 32'hE5, 1'b1, D_T);

        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) check("queue_empty", 64'(exp_q[i].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
